// File: rtl/fifo_pkg.sv
// Shared types for the parameterised FIFO: control-FSM state encoding and
// the pointer-width helper used to size addresses from DEPTH.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MID   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  // Address width for a power-of-two DEPTH; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// FIFO storage: WIDTH x DEPTH array with one write port and a registered
// read port that can alternatively capture the write data (empty bypass).
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  input  logic             i_byp,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Output register clears on reset only; otherwise it changes solely on a
  // read or a bypass and holds across flushes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_byp) begin
      r_rdata <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_param.sv
// Single-clock FIFO with EMPTY/MID/FULL control FSM, occupancy count,
// registered-decode flags, sticky overflow/underflow and empty bypass.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   CLEAR_N,
  input  logic                   WRITE,
  input  logic                   READ,
  input  logic [WIDTH-1:0]       DATA_IN,
  output logic [WIDTH-1:0]       DATA_OUT,
  output logic [$clog2(DEPTH):0] USE_DW,
  output logic                   F_FULL_N,
  output logic                   F_EMPTY_N,
  output logic                   F_ALMOST_FULL,
  output logic                   F_ALMOST_EMPTY,
  output logic                   OVERFLOW,
  output logic                   UNDERFLOW
);

  localparam int unsigned AW = ptr_width(DEPTH);
  localparam int unsigned CW = AW + 1;

  fifo_state_t r_state, w_state_nxt;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_ovf, r_unf;

  logic w_wr_only, w_rd_only, w_both;
  logic w_do_wr, w_do_rd, w_byp, w_drop, w_ign;
  logic w_en;
  logic [31:0] w_cnt32;

  assign w_wr_only = WRITE & ~READ;
  assign w_rd_only = READ & ~WRITE;
  assign w_both    = WRITE & READ;
  assign w_en      = ~RESET & CLEAR_N;

  always_comb begin
    w_do_wr = 1'b0;
    w_do_rd = 1'b0;
    w_byp   = 1'b0;
    w_drop  = 1'b0;
    w_ign   = 1'b0;
    unique case (r_state)
      EMPTY: begin
        w_do_wr = w_wr_only;
        w_byp   = w_both;
        w_ign   = w_rd_only;
      end
      MID: begin
        w_do_wr = WRITE;
        w_do_rd = READ;
      end
      FULL: begin
        w_do_wr = w_both;
        w_do_rd = READ;
        w_drop  = w_wr_only;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: if (w_wr_only) w_state_nxt = MID;
      MID: begin
        if (w_wr_only && r_cnt == CW'(DEPTH - 1)) begin
          w_state_nxt = FULL;
        end else if (w_rd_only && r_cnt == CW'(1)) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL:  if (w_rd_only) w_state_nxt = MID;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Reset and flush share the control-state clear; they differ only in
  // whether DATA_OUT is zeroed, which lives in the storage block.
  always_ff @(posedge CLOCK) begin
    if (RESET || !CLEAR_N) begin
      r_state <= EMPTY;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_do_wr) r_wptr <= r_wptr + AW'(1);
      if (w_do_rd) r_rptr <= r_rptr + AW'(1);
      if (w_do_wr && !w_do_rd) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_do_rd && !w_do_wr) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_drop) r_ovf <= 1'b1;
      if (w_ign)  r_unf <= 1'b1;
    end
  end

  fifo_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (CLOCK),
    .i_rst   (RESET),
    .i_we    (w_do_wr & w_en),
    .i_waddr (r_wptr),
    .i_wdata (DATA_IN),
    .i_re    (w_do_rd & w_en),
    .i_raddr (r_rptr),
    .i_byp   (w_byp & w_en),
    .o_rdata (DATA_OUT)
  );

  assign w_cnt32        = 32'(r_cnt);
  assign USE_DW         = r_cnt;
  assign F_FULL_N       = (r_state != FULL);
  assign F_EMPTY_N      = (r_state != EMPTY);
  assign F_ALMOST_FULL  = (w_cnt32 >= AF_LEVEL);
  assign F_ALMOST_EMPTY = (w_cnt32 <= AE_LEVEL);
  assign OVERFLOW       = r_ovf;
  assign UNDERFLOW      = r_unf;

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DEPTH, default 32: number of storage words; SHALL be a power of two and at least 4.
REQ-002 Parameter WIDTH, default 8: data word width in bits.
REQ-003 Parameter AF_LEVEL, default DEPTH-4: almost-full threshold on the occupancy count.
REQ-004 Parameter AE_LEVEL, default 4: almost-empty threshold on the occupancy count.
REQ-005 CLOCK  in  1  single clock; all state changes on its rising edge.
REQ-006 RESET  in  1  synchronous reset, active-high.
REQ-007 CLEAR_N  in  1  synchronous flush, active-low; lower priority than RESET.
REQ-008 WRITE  in  1  write request.
REQ-009 READ  in  1  read request.
REQ-010 DATA_IN  in  WIDTH  write data.
REQ-011 DATA_OUT  out  WIDTH  read data, registered.
REQ-012 USE_DW  out  $clog2(DEPTH)+1  occupancy count, 0..DEPTH inclusive.
REQ-013 F_FULL_N  out  1  low when USE_DW==DEPTH.
REQ-014 F_EMPTY_N  out  1  low when USE_DW==0.
REQ-015 F_ALMOST_FULL  out  1  high when USE_DW>=AF_LEVEL.
REQ-016 F_ALMOST_EMPTY  out  1  high when USE_DW<=AE_LEVEL.
REQ-017 OVERFLOW  out  1  sticky; set by a dropped write.
REQ-018 UNDERFLOW  out  1  sticky; set by an ignored read.

Function
REQ-019 The control FSM SHALL have three states: EMPTY, MID and FULL.
REQ-020 EMPTY->MID on write-only; MID->FULL on write-only at USE_DW==DEPTH-1; MID->EMPTY on read-only at USE_DW==1; FULL->MID on read-only; all other cases hold state.
REQ-021 Flags SHALL be decoded from state and USE_DW registers only, with no combinational path from READ/WRITE.
REQ-022 An accepted write SHALL store DATA_IN at the write pointer, advance the write pointer modulo DEPTH, and increment USE_DW.
REQ-023 An accepted read SHALL load DATA_OUT from the read pointer on the same edge (1-cycle latency), advance the read pointer modulo DEPTH, and decrement USE_DW.
REQ-024 Simultaneous READ and WRITE in MID or FULL SHALL accept both, leaving USE_DW unchanged.
REQ-025 Simultaneous READ and WRITE in EMPTY SHALL bypass: DATA_OUT<=DATA_IN next cycle, with pointers, USE_DW and state unchanged and UNDERFLOW not set.
REQ-026 WRITE without READ in FULL SHALL be dropped, with memory and pointers unchanged, and SHALL set OVERFLOW.
REQ-027 READ without WRITE in EMPTY SHALL be ignored, with DATA_OUT held, and SHALL set UNDERFLOW.
REQ-028 DATA_OUT SHALL hold its value whenever no read or bypass occurs.
REQ-029 OVERFLOW and UNDERFLOW SHALL remain set until RESET or CLEAR_N.
REQ-030 CLEAR_N low SHALL take effect for one cycle and override READ/WRITE in that cycle: pointers, USE_DW and sticky flags cleared, state set to EMPTY; DATA_OUT and memory contents are unchanged.

Reset
REQ-031 RESET high SHALL set, on the next edge, state=EMPTY, both pointers=0 and USE_DW=0.
REQ-032 RESET high SHALL also set, on the next edge, DATA_OUT=0, F_EMPTY_N=0, F_FULL_N=1, F_ALMOST_EMPTY=1, F_ALMOST_FULL=0 and OVERFLOW=UNDERFLOW=0.
REQ-033 RESET asserted mid-operation SHALL discard all stored words; memory contents are not cleared.

Structure
REQ-034 Package fifo_pkg SHALL hold the FSM state typedef (EMPTY, MID, FULL) and a function computing the pointer width from DEPTH.
REQ-035 Storage SHALL be one sub-module, fifo_dpram (WIDTH x DEPTH, one write port, registered read port, write enable, read enable); pointers, count, FSM and flags SHALL live in fifo_param.

Verification
REQ-036 DEPTH=8, WIDTH=8: after reset, write 0x01..0x08 -> F_FULL_N=0, USE_DW=8, F_ALMOST_FULL=1; then read 8 -> DATA_OUT 0x01..0x08, each 1 cycle after READ, ending with F_EMPTY_N=0.
REQ-037 On a full FIFO, write 0xAA without READ -> OVERFLOW=1, USE_DW=8; the following 8 reads return 0x01..0x08 with no 0xAA.
REQ-038 On an empty FIFO, pulse READ -> UNDERFLOW=1, DATA_OUT unchanged; then READ+WRITE with 0x5C -> DATA_OUT=0x5C next cycle, USE_DW=0.
REQ-039 Hold USE_DW=4 with READ+WRITE for 20 cycles (pointer wrap) -> USE_DW stays 4 and data emerges in order.
REQ-040 With 5 words stored, assert CLEAR_N=0 together with WRITE -> next cycle USE_DW=0, F_EMPTY_N=0 and sticky flags cleared.
REQ-041 With 6 words stored, assert RESET for one cycle -> all REQ-032 values hold on the following cycle.
